// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the distance between rising edges on a pulse
// input and reports it as "ticks" (edge-to-edge cycles minus one). This is the
// inverse of the periodic pulse generator's encoding.
//
// Results leave through a single-entry output register with valid/ready
// semantics. period_valid rises when a result is loaded and stays high, with
// period stable, until a cycle where period_valid & period_ready are both
// high; that cycle is the transfer. If a new result is loaded in that same
// cycle, period_valid stays high.
//
// Registered one-cycle strobes:
//   overflow: no edge arrived within 2^N cycles while measuring.
//   dropped:  a result was discarded because the output register was full.
// Both strobes appear one clock after the triggering cycle, aligned with
// period/period_valid.
//
// o_dbg_state exposes the FSM state: 0 = IDLE, 1 = ARMED, 2 = MEASURING.
module pulse_period_meter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in,
  output logic [N-1:0] period,
  output logic         period_valid,
  input  logic         period_ready,
  output logic         overflow,
  output logic         dropped,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_MEASURING = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_cnt;
  logic [N-1:0] w_cnt_nxt;
  logic         r_in_q;
  logic [N-1:0] r_period;
  logic         r_period_valid;
  logic         r_overflow;
  logic         r_dropped;

  logic         w_edge;
  logic         w_result_vld;
  logic         w_overflow;
  logic         w_xfer;
  logic         w_load;

  // The previous-input register resets high so a level already high
  // coming out of reset does not count as an edge.
  assign w_edge = in & ~r_in_q;
  assign w_xfer = r_period_valid & period_ready;
  // A result is accepted when the output is empty or being emptied now.
  assign w_load = w_result_vld & (~r_period_valid | w_xfer);

  // FSM next-state and counter logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_result_vld = 1'b0;
    w_overflow   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (ena) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        // First edge only starts the measurement.
        if (w_edge) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_MEASURING;
        end
      end
      ST_MEASURING: begin
        if (w_edge) begin
          // An edge at cnt == max is still a valid result, not an overflow.
          w_result_vld = 1'b1;
          w_cnt_nxt    = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_overflow  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ARMED;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Disabling wins over everything except a result already captured above.
    if (!ena) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // FSM state, counter and edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_in_q  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_in_q  <= in;
    end
  end

  // Output register with valid/ready handshake and status strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_dropped      <= 1'b0;
    end else begin
      r_overflow <= w_overflow;
      r_dropped  <= w_result_vld & ~w_load;
      if (w_load) begin
        r_period       <= r_cnt;
        r_period_valid <= 1'b1;
      end else if (w_xfer) begin
        r_period_valid <= 1'b0;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
  assign overflow     = r_overflow;
  assign dropped      = r_dropped;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (N=8). Inputs change 1 ns after each
// rising clock edge; outputs are sampled at that same point, so they show the
// registers updated by the edge just passed.
module tb_pulse_period_meter;

  localparam int N = 8;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ARMED     = 2'd1;
  localparam logic [1:0] S_MEASURING = 2'd2;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         in;
  logic [N-1:0] period;
  logic         period_valid;
  logic         period_ready;
  logic         overflow;
  logic         dropped;
  logic [1:0]   dbg_state;

  int vectors;
  int miscompares;

  pulse_period_meter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in           (in),
    .period       (period),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overflow     (overflow),
    .dropped      (dropped),
    .o_dbg_state  (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; afterwards inputs may change and outputs may be read
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // one-cycle high pulse; on return the edge has been sampled
  task automatic pulse();
    in = 1'b1;
    tick();
    in = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ovf_seen;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    ena          = 1'b0;
    in           = 1'b0;
    period_ready = 1'b0;
    #1;
    idle(2);

    // reset state
    chk("rst_valid", {31'd0, period_valid}, 0);
    chk("rst_period", {24'd0, period}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_dropped", {31'd0, dropped}, 0);
    chk("rst_state", {30'd0, dbg_state}, S_IDLE);

    // train with spacing 6, ready held high
    rst = 1'b0;
    ena = 1'b1;
    period_ready = 1'b1;
    idle(1);
    chk("armed_state", {30'd0, dbg_state}, S_ARMED);
    idle(2);
    pulse();
    chk("arm_no_result", {31'd0, period_valid}, 0);
    chk("arm_to_meas", {30'd0, dbg_state}, S_MEASURING);
    idle(5);
    pulse();
    chk("t6_valid", {31'd0, period_valid}, 1);
    chk("t6_period", {24'd0, period}, 5);
    chk("t6_overflow", {31'd0, overflow}, 0);
    idle(1);
    chk("t6_valid_one_cycle", {31'd0, period_valid}, 0);
    idle(4);
    pulse();
    chk("t6b_valid", {31'd0, period_valid}, 1);
    chk("t6b_period", {24'd0, period}, 5);

    // ready low: result held, later results dropped
    period_ready = 1'b0;
    idle(1);
    chk("hold_valid", {31'd0, period_valid}, 1);
    idle(4);
    pulse();
    chk("drop1_strobe", {31'd0, dropped}, 1);
    chk("drop1_period", {24'd0, period}, 5);
    chk("drop1_valid", {31'd0, period_valid}, 1);
    idle(1);
    chk("drop1_strobe_end", {31'd0, dropped}, 0);
    idle(1);
    // spacing 3 with ready raised on the result cycle: transfer plus reload
    period_ready = 1'b1;
    pulse();
    chk("reload_valid", {31'd0, period_valid}, 1);
    chk("reload_period", {24'd0, period}, 2);
    chk("reload_no_drop", {31'd0, dropped}, 0);
    idle(1);
    chk("reload_xfer", {31'd0, period_valid}, 0);

    // spacing 5 -> 4
    idle(3);
    pulse();
    chk("t5_period", {24'd0, period}, 4);

    // spacing 256 -> 255, no overflow
    idle(255);
    pulse();
    chk("t256_valid", {31'd0, period_valid}, 1);
    chk("t256_period", {24'd0, period}, 255);
    chk("t256_overflow", {31'd0, overflow}, 0);

    // spacing 257 -> overflow, then the late edge only re-arms
    idle(255);
    chk("t257_pre_overflow", {31'd0, overflow}, 0);
    idle(1);
    chk("t257_overflow", {31'd0, overflow}, 1);
    chk("t257_state", {30'd0, dbg_state}, S_ARMED);
    pulse();
    chk("t257_rearm_no_result", {31'd0, period_valid}, 0);
    chk("t257_overflow_end", {31'd0, overflow}, 0);
    idle(6);
    pulse();
    chk("after_ovf_period", {24'd0, period}, 6);
    chk("after_ovf_valid", {31'd0, period_valid}, 1);

    // in held high after a rising edge: one overflow, then idle in ARMED
    idle(2);
    in = 1'b1;
    tick();
    chk("hold_hi_period", {24'd0, period}, 2);
    idle(255);
    chk("hold_hi_pre_ovf", {31'd0, overflow}, 0);
    idle(1);
    chk("hold_hi_ovf", {31'd0, overflow}, 1);
    ovf_seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (overflow === 1'b1 || period_valid === 1'b1) ovf_seen++;
    end
    chk("hold_hi_quiet", ovf_seen, 0);

    // pulses 2 cycles apart -> ticks 1
    in = 1'b0;
    tick();
    pulse();
    chk("t2_arm", {31'd0, period_valid}, 0);
    idle(1);
    pulse();
    chk("t2_period", {24'd0, period}, 1);
    chk("t2_valid", {31'd0, period_valid}, 1);
    idle(1);
    pulse();
    chk("t2b_period", {24'd0, period}, 1);
    chk("t2b_valid", {31'd0, period_valid}, 1);

    // ena low for 3 cycles with a pending result
    period_ready = 1'b0;
    idle(3);
    ena = 1'b0;
    idle(3);
    chk("ena_off_state", {30'd0, dbg_state}, S_IDLE);
    chk("ena_off_valid", {31'd0, period_valid}, 1);
    chk("ena_off_period", {24'd0, period}, 1);
    ena = 1'b1;
    idle(1);
    chk("ena_on_state", {30'd0, dbg_state}, S_ARMED);
    period_ready = 1'b1;
    idle(1);
    chk("ena_on_xfer", {31'd0, period_valid}, 0);
    pulse();
    chk("ena_on_arm", {31'd0, period_valid}, 0);
    idle(3);
    pulse();
    chk("ena_on_period", {24'd0, period}, 3);
    chk("ena_on_valid", {31'd0, period_valid}, 1);

    // reset mid-count with a pending result and in held high across reset
    period_ready = 1'b0;
    idle(4);
    in  = 1'b1;
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, period_valid}, 0);
    chk("mid_rst_period", {24'd0, period}, 0);
    chk("mid_rst_state", {30'd0, dbg_state}, S_IDLE);
    rst = 1'b0;
    idle(4);
    chk("post_rst_no_edge", {30'd0, dbg_state}, S_ARMED);
    in = 1'b0;
    tick();
    pulse();
    chk("post_rst_arm_state", {30'd0, dbg_state}, S_MEASURING);
    chk("post_rst_arm_valid", {31'd0, period_valid}, 0);
    idle(3);
    pulse();
    chk("post_rst_period", {24'd0, period}, 3);
    chk("post_rst_valid", {31'd0, period_valid}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

endmodule
